// File: rtl/mp_mem_arbiter.sv
// rtl/mp_mem_arbiter.sv - N-processor shared-memory arbiter with round-robin/fixed priority and timeout
module mp_mem_arbiter #(
  parameter int NUM_PROC = 4,
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int MODE     = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_PROC-1:0]    req,
  input  logic [NUM_PROC-1:0]    we,
  input  logic [NUM_PROC*AW-1:0] addr,
  input  logic [NUM_PROC*DW-1:0] wdata,
  output logic [NUM_PROC-1:0]    gnt,
  output logic [NUM_PROC-1:0]    ack,
  output logic                   err,
  output logic [DW-1:0]          rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic [DW-1:0]          mem_rdata,
  input  logic                   mem_ready,
  output logic                   busy
);

  localparam int IW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  // A zero TIMEOUT disables the abort, but the counter still needs one bit to exist.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_PROC - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [NUM_PROC-1:0]   gnt_q, gnt_d;
  logic [NUM_PROC-1:0]   ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [DW-1:0]         mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic [IW-1:0]         last_owner_q, last_owner_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  win_found;
  logic [IW-1:0]         win_idx;
  logic [IW-1:0]         cand_idx;
  logic [NUM_PROC-1:0]   win_oh;
  logic [AW-1:0]         sel_addr;
  logic [DW-1:0]         sel_wdata;

  // Winner selection: lowest index in fixed mode, first requester after last_owner in round-robin.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    if (MODE == 1) begin
      for (int i = NUM_PROC - 1; i >= 0; i--) begin
        if (req[i]) begin
          win_found = 1'b1;
          win_idx   = IW'(i);
        end
      end
    end else begin
      for (int i = 1; i <= NUM_PROC; i++) begin
        cand_idx = IW'((int'(last_owner_q) + i) % NUM_PROC);
        if (!win_found && req[cand_idx]) begin
          win_found = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end
  end

  // Route the winner's request fields; constant slices keep the mux width-clean.
  always_comb begin
    win_oh    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (IW'(i) == win_idx) begin
        win_oh[i] = 1'b1;
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    ack_d        = ack_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    busy_d       = busy_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d      = S_BUSY;
          gnt_d        = win_oh;
          mem_req_d    = 1'b1;
          mem_we_d     = we[win_idx];
          mem_addr_d   = sel_addr;
          mem_wdata_d  = sel_wdata;
          busy_d       = 1'b1;
          last_owner_d = win_idx;
          cnt_d        = '0;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end
          state_d   = S_DONE;
          ack_d     = gnt_q;
          err_d     = 1'b0;
          gnt_d     = '0;
          mem_req_d = 1'b0;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d   = S_DONE;
          ack_d     = gnt_q;
          err_d     = 1'b1;
          gnt_d     = '0;
          mem_req_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ack_d   = '0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction without an ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      ack_q        <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      last_owner_q <= LAST_RST;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
